// File: rtl/gshare_pattern_history_table.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : gshare_pattern_history_table                                 |
// | Description : Gshare PHT of ENTRY_NUM 2-bit saturating counters. Registered |
// |               lookup (latency 1) and a 2-stage read-modify-write training |
// |               path with write-first bypass. The table is swept to         |
// |               INIT_STATE after reset before it reports ready.             |
// | Options     : define GSHARE_PHT_PERF_EN for update/mispredict counters.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module gshare_pattern_history_table #(
  parameter int         ENTRY_NUM  = 8192,
  parameter int         INDEX_BITS = $clog2(ENTRY_NUM),
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  lookup_valid,
  input  logic [INDEX_BITS-1:0] lookup_index,
  output logic                  pred_valid,
  output logic                  pred_taken,
  output logic [1:0]            pred_counter,
  input  logic                  update_en,
  input  logic [INDEX_BITS-1:0] update_index,
  input  logic                  update_taken,
  input  logic                  update_mispredict,
  output logic                  pht_ready
`ifdef GSHARE_PHT_PERF_EN
  ,
  output logic [31:0]           perf_updates,
  output logic [31:0]           perf_mispredicts
`endif
);

  localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(ENTRY_NUM - 1);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                  state;
  logic [INDEX_BITS-1:0]   init_ptr;
  logic [1:0]              mem [ENTRY_NUM];

  // Write stage (U2) registers: one training update being written this cycle
  logic                    u2_valid;
  logic [INDEX_BITS-1:0]   u2_index;
  logic                    u2_taken;
  logic [1:0]              u2_old;
  logic [1:0]              u2_new;

  logic                    lookup_hit;
  logic                    update_hit;
  logic [1:0]              lookup_data;
  logic [1:0]              update_old;

  // Init sweep sequencer: walks every entry once, then stays ready until reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_INIT;
      init_ptr  <= '0;
      pht_ready <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          init_ptr <= init_ptr + 1'b1;
          if (init_ptr == LAST_IDX) begin
            state     <= ST_READY;
            pht_ready <= 1'b1;
          end
        end
        ST_READY: begin
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // Counter array: sweep writes during init, trained values once ready
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[init_ptr] <= INIT_STATE;
    end else if (u2_valid) begin
      mem[u2_index] <= u2_new;
    end
  end

  // Saturating 2-bit counter step for the update being written
  always_comb begin
    u2_new = u2_old;
    if (u2_taken) begin
      if (u2_old != 2'b11) u2_new = u2_old + 2'd1;
    end else begin
      if (u2_old != 2'b00) u2_new = u2_old - 2'd1;
    end
  end

  // The in-flight write wins over the stale array contents for both readers
  assign lookup_hit  = u2_valid && (u2_index == lookup_index);
  assign update_hit  = u2_valid && (u2_index == update_index);
  assign lookup_data = lookup_hit ? u2_new : mem[lookup_index];
  assign update_old  = update_hit ? u2_new : mem[update_index];

  // Read stage (U1): capture the training request and its current counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      u2_valid <= 1'b0;
      u2_index <= '0;
      u2_taken <= 1'b0;
      u2_old   <= 2'b00;
    end else begin
      u2_valid <= update_en & pht_ready;
      u2_index <= update_index;
      u2_taken <= update_taken;
      u2_old   <= update_old;
    end
  end

  // Registered prediction; data holds when no accepted lookup
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pred_valid   <= 1'b0;
      pred_taken   <= 1'b0;
      pred_counter <= 2'b00;
    end else begin
      pred_valid <= lookup_valid & pht_ready;
      if (lookup_valid & pht_ready) begin
        pred_counter <= lookup_data;
        pred_taken   <= lookup_data[1];
      end
    end
  end

`ifdef GSHARE_PHT_PERF_EN
  logic u2_mispredict;

  // Mispredict flag travels alongside the update into the write stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) u2_mispredict <= 1'b0;
    else       u2_mispredict <= update_mispredict;
  end

  // Performance counters advance on each committed table write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_updates     <= '0;
      perf_mispredicts <= '0;
    end else if (u2_valid) begin
      perf_updates <= perf_updates + 32'd1;
      if (u2_mispredict) perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end
`else
  logic unused_mispredict;
  assign unused_mispredict = update_mispredict;
`endif

endmodule
`default_nettype wire
